// File: rtl/common_types_pkg.sv
// Shared types for the core's RAM request path.
//   word_t              : 32-bit data/address word
//   ram_state_t         : responder handshake state (RAM_IDLE/RAM_WAIT/RAM_DONE)
//   ram_index_t         : word index at the widest supported depth
//   ram_resv_t          : load-reserved reservation {valid, index}
//   RAM_LATENCY_DEFAULT : default wait-state count
//   ram_merge_lanes()   : byte-lane merge used by strobed stores
package common_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_DONE = 2'd2
    } ram_state_t;

    localparam int unsigned RAM_LATENCY_DEFAULT = 2;
    localparam int unsigned RAM_INDEX_MAX_BITS  = 30;

    typedef logic [RAM_INDEX_MAX_BITS-1:0] ram_index_t;

    typedef struct packed {
        logic       valid;
        ram_index_t index;
    } ram_resv_t;

    function automatic word_t ram_merge_lanes(input word_t old_w, input word_t new_w,
                                              input logic [3:0] strobe);
        word_t res;
        res = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strobe[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port DEPTH_WORDS x 32 storage with registered read and byte-lane write.
// Storage itself is never reset; only the read register is.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset of the read register
//   re_i     : load rdata_o from the addressed word (pre-write value)
//   we_i     : write enabled lanes of wdata_i into the addressed word
//   idx_i    : word index
//   wdata_i  : store data, lane-aligned
//   strobe_i : byte-lane write enables
//   rdata_o  : registered read data, holds between reads
module sram_bank
    import common_types_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 re_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] idx_i,
    input  word_t                wdata_i,
    input  logic [3:0]           strobe_i,
    output word_t                rdata_o
);

    word_t mem_q [DEPTH_WORDS];
    word_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= ram_merge_lanes(mem_q[idx_i], wdata_i, strobe_i);
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the core's RAM request interface. Accepts one
// read or write at a time, waits LATENCY cycles, commits, then pulses ready.
// Optional load-reserved/store-conditional support: define RAM_LRSC_EN.
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   ren, wen      : read / write request, held until ready (both = write)
//   addr          : byte address, bits [1:0] ignored, upper bits wrap
//   wdata, strobe : store data and byte-lane enables
//   lr, sc        : load-reserved / store-conditional qualifiers
//   ready         : one-cycle completion pulse
//   rdata         : read data, valid while ready
//   sc_fail       : store-conditional failed, valid while ready
module ram_responder
    import common_types_pkg::*;
#(
    parameter  int unsigned LATENCY     = RAM_LATENCY_DEFAULT,
    parameter  int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ren,
    input  logic       wen,
    input  word_t      addr,
    input  word_t      wdata,
    input  logic [3:0] strobe,
    input  logic       lr,
    input  logic       sc,
    output logic       ready,
    output word_t      rdata,
    output logic       sc_fail
);

    localparam int unsigned     CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    ram_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    word_t                wdata_q, wdata_d;
    logic [3:0]           strobe_q, strobe_d;
    logic                 ren_op_q, ren_op_d;
    logic                 wen_op_q, wen_op_d;
    logic                 sc_fail_q, sc_fail_d;
    logic                 commit, commit_en;
    logic                 bank_re, bank_we;

`ifdef RAM_LRSC_EN
    logic      lr_q, lr_d;
    logic      sc_q, sc_d;
    ram_resv_t resv_q, resv_d;
    logic      sc_op, resv_hit;
    logic      unused_addr;
    assign unused_addr = &{1'b0, addr[31:ADDR_BITS+2], addr[1:0]};
`else
    logic unused_inputs;
    assign unused_inputs = &{1'b0, addr[31:ADDR_BITS+2], addr[1:0], lr, sc};
`endif

    // The *_d copies equal the live request on the accept edge and the latched
    // copy afterwards, so commit logic reads them and LATENCY=0 needs no
    // special case.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        strobe_d = strobe_q;
        ren_op_d = ren_op_q;
        wen_op_d = wen_op_q;
`ifdef RAM_LRSC_EN
        lr_d     = lr_q;
        sc_d     = sc_q;
`endif
        commit   = 1'b0;
        case (state_q)
            RAM_IDLE: begin
                if (ren || wen) begin
                    idx_d    = addr[ADDR_BITS+1:2];
                    wdata_d  = wdata;
                    strobe_d = strobe;
                    ren_op_d = ren;
                    wen_op_d = wen;
`ifdef RAM_LRSC_EN
                    lr_d     = lr;
                    sc_d     = sc;
`endif
                    if (LATENCY == 0) begin
                        state_d = RAM_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = RAM_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            RAM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RAM_DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RAM_DONE: state_d = RAM_IDLE;
            default:  state_d = RAM_IDLE;
        endcase
    end

    // Reset on the commit edge suppresses both the storage write and the read.
    always_comb begin
        commit_en = commit & ~rst;
        bank_re   = commit_en & ren_op_d;
        sc_fail_d = sc_fail_q;
`ifdef RAM_LRSC_EN
        resv_d    = resv_q;
        sc_op     = wen_op_d & sc_d;
        resv_hit  = resv_q.valid & (resv_q.index == ram_index_t'(idx_d));
        bank_we   = commit_en & wen_op_d & (~sc_op | resv_hit);
        if (commit_en) begin
            sc_fail_d = sc_op & ~resv_hit;
            if (sc_op || (wen_op_d && resv_hit)) begin
                resv_d.valid = 1'b0;
            end else if (ren_op_d && !wen_op_d && lr_d) begin
                resv_d.valid = 1'b1;
                resv_d.index = ram_index_t'(idx_d);
            end
        end
`else
        bank_we   = commit_en & wen_op_d;
        if (commit_en) sc_fail_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RAM_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strobe_q  <= '0;
            ren_op_q  <= 1'b0;
            wen_op_q  <= 1'b0;
            sc_fail_q <= 1'b0;
`ifdef RAM_LRSC_EN
            lr_q      <= 1'b0;
            sc_q      <= 1'b0;
            resv_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            strobe_q  <= strobe_d;
            ren_op_q  <= ren_op_d;
            wen_op_q  <= wen_op_d;
            sc_fail_q <= sc_fail_d;
`ifdef RAM_LRSC_EN
            lr_q      <= lr_d;
            sc_q      <= sc_d;
            resv_q    <= resv_d;
`endif
        end
    end

    sram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk_i    (clk),
        .rst_i    (rst),
        .re_i     (bank_re),
        .we_i     (bank_we),
        .idx_i    (idx_d),
        .wdata_i  (wdata_d),
        .strobe_i (strobe_d),
        .rdata_o  (rdata)
    );

    assign ready   = (state_q == RAM_DONE);
    assign sc_fail = sc_fail_q;

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
Memory-side responder for the core's RAM request interface: the end that the core's RAM_IDLE/RAM_WAIT/RAM_DONE requester waits on.
- Accepts one read or write request at a time.
- Inserts a programmable number of wait states.
- Commits byte-strobed writes and returns registered read data with a one-cycle ready pulse.
- Sits between the core's fetch/memory arbiter and on-chip word-organised storage.

Parameters:
- LATENCY, 2: wait-state cycles between accept and ready (0 allowed).
- DEPTH_WORDS, 4096: storage depth in 32-bit words (power of two).
- ADDR_BITS, $clog2(DEPTH_WORDS): word-index width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ren  in  1  read request, held by requester until ready.
- wen  in  1  write request, held by requester until ready.
- addr  in  32 (word_t)  byte address; bits [1:0] ignored.
- wdata  in  32 (word_t)  store data, lane-aligned.
- strobe  in  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
- lr  in  1  qualifies ren as load-reserved.
- sc  in  1  qualifies wen as store-conditional.
- ready  out  1  one-cycle completion pulse.
- rdata  out  32 (word_t)  read data, valid while ready=1.
- sc_fail  out  1  store-conditional failed, valid while ready=1.

Behaviour:
- State register type: ram_state_t (RAM_IDLE, RAM_WAIT, RAM_DONE).
- Reset values: state=RAM_IDLE, ready=0, rdata=0, sc_fail=0, wait counter=0, reservation invalid. Storage is not reset.
- RAM_IDLE, (ren|wen)=1 in cycle T:
  - Latch word index = addr[ADDR_BITS+1:2], wdata, strobe, op, lr, sc.
  - If LATENCY=0, go to RAM_DONE; otherwise go to RAM_WAIT with cnt=LATENCY-1.
- RAM_WAIT: if cnt=0, go to RAM_DONE; else cnt--.
- Commit on the edge entering RAM_DONE:
  - Write: update only the lanes whose strobe bit is 1.
  - Read: rdata <= mem[index].
- RAM_DONE: ready=1 for exactly one cycle, then RAM_IDLE. Ready therefore appears in cycle T+1+LATENCY.
- Request inputs sampled outside RAM_IDLE are ignored; the latched copy is authoritative.
- The earliest next accept is the cycle after RAM_DONE, so back-to-back throughput is one access per LATENCY+2 cycles.
- ren&wen both high: treated as a write. rdata returns the pre-write word.
- wen with strobe=0: completes normally, storage unchanged.
- Addresses beyond DEPTH_WORDS wrap, because only low index bits are used.
- rst during RAM_WAIT or on the commit edge: rst wins, no write is committed, state returns to RAM_IDLE, ready stays 0.
- Outside RAM_DONE, rdata holds its last value and ready=0.

Optional Feature:
Macro: RAM_LRSC_EN.
- Defined:
  - One reservation register {valid, index}.
  - ren&lr completion sets valid=1 and index=latched index.
  - wen&sc completion:
    - On match (valid and same index): write, sc_fail=0.
    - Otherwise: no write, sc_fail=1.
    - Valid is cleared in either case.
  - An ordinary write to the reserved index clears valid.
- Undefined: lr and sc are ignored, sc behaves as a plain write, and sc_fail is tied to 0.
- Ports are present in both builds.

Decomposition:
Shared package (common_types_pkg):
- Reuse ram_state_t and word_t.
- Add a ram_resv_t packed struct {valid, index}.
- Add a RAM_LATENCY_DEFAULT constant.

Sub-module: sram_bank, a single-port DEPTH_WORDS x 32 array with a registered read and 4-lane byte-enable write. ram_responder owns the FSM, counter and reservation.

Test Plan:
1. LATENCY=2: write addr=0x10, wdata=0xDEADBEEF, strobe=0xF at T; then read 0x10. Required: ready at T+3 for the write; the read returns 0xDEADBEEF with ready 3 cycles after its accept.
2. Partial store: strobe=0x2, wdata=0x0000AB00 to 0x10. Required: subsequent read = 0xDEADABEF.
3. LATENCY=0: read accept at T. Required: ready at T+1. Back-to-back held ren. Required: accepts at T, T+2, T+4.
4. Reset on the cycle before a write's ready (wen to 0x20 with 0x12345678, rst=1). Required: ready never pulses; a later read of 0x20 returns the prior contents (seed with 0x0).
5. Wrap and collision: DEPTH_WORDS=4096; write 0x4010 with 0x55. Required: read 0x10 = 0x55. ren&wen together. Required: old word returned, new word stored.
6. RAM_LRSC_EN:
   - lr 0x40, then sc 0x40 with 0x1. Required: sc_fail=0, word=0x1.
   - lr 0x40, plain write 0x40, then sc 0x40. Required: sc_fail=1, no write.
   - sc without any prior lr. Required: sc_fail=1.
